// File: rtl/cmp_search_pkg.sv
// Shared types and sizing helpers for the comparator-driven binary search controller.
package cmp_search_pkg;

  // Default operand width of the comparator interface.
  parameter int unsigned DefaultWidth = 8;

  // Controller states.
  typedef enum logic [1:0] {
    StIdle,
    StProbe,
    StDone
  } state_t;

  // Step counter width: must hold the worst case of width+1 probes.
  function automatic int unsigned calc_step_w(input int unsigned width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/cmp_search_ctrl.sv
// Binary-search initiator: drives a probe into an external relational comparator
// and narrows [lo, hi] on the returned EQ/GT/LT flags until the target is found.
module cmp_search_ctrl
  import cmp_search_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  localparam int unsigned STEP_W = calc_step_w(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic [WIDTH-1:0]  probe_o,
  output logic              probe_valid_o,
  input  logic              cmp_valid_i,
  input  logic              eq_i,
  input  logic              gt_i,
  input  logic              lt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              found_o,
  output logic              err_o,
  output logic [WIDTH-1:0]  result_o,
  output logic [STEP_W-1:0] steps_o
);

  localparam logic [WIDTH-1:0]  One     = WIDTH'(1);
  localparam logic [STEP_W-1:0] StepOne = STEP_W'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [STEP_W-1:0]  steps_q, steps_d;
  logic               found_q, found_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pvalid_q, pvalid_d;
  logic [WIDTH-1:0]   mid;
  logic               flags_onehot;

  // Midpoint of [lo, hi]; lo <= hi always holds, so hi - lo and the sum cannot wrap.
  assign mid          = lo_q + ((hi_q - lo_q) >> 1);
  assign flags_onehot = $onehot({eq_i, gt_i, lt_i});

  assign probe_o       = pvalid_q ? mid : '0;
  assign probe_valid_o = pvalid_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign found_o       = found_q;
  assign err_o         = err_q;
  assign result_o      = result_q;
  assign steps_o       = steps_q;

  // Next-state logic: search window update and result capture on each response.
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    result_d = result_q;
    steps_d  = steps_q;
    found_d  = found_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          lo_d    = '0;
          hi_d    = '1;
          steps_d = '0;
          found_d = 1'b0;
          err_d   = 1'b0;
          state_d = StProbe;
        end
      end
      StProbe: begin
        if (cmp_valid_i) begin
          if (steps_q != '1) steps_d = steps_q + StepOne;
          result_d = mid;
          if (!flags_onehot) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (eq_i) begin
            found_d = 1'b1;
            state_d = StDone;
          end else if (gt_i) begin
            if (mid == hi_q) state_d = StDone;
            else             lo_d    = mid + One;
          end else begin
            if (mid == lo_q) state_d = StDone;
            else             hi_d    = mid - One;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d   = (state_d == StProbe);
    pvalid_d = (state_d == StProbe);
    done_d   = (state_d == StDone);
  end

  // State and output registers; reset aborts any search without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      lo_q     <= '0;
      hi_q     <= '1;
      result_q <= '0;
      steps_q  <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      result_q <= result_d;
      steps_q  <= steps_d;
      found_q  <= found_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pvalid_q <= pvalid_d;
    end
  end

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Directed table-driven bench for cmp_search_ctrl with a relational comparator responder.
module tb_cmp_search_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] probe_o;
  logic       probe_valid_o;
  logic       cmp_valid_i = 1'b0;
  logic       eq_i, gt_i, lt_i;
  logic       busy_o, done_o, found_o, err_o;
  logic [7:0] result_o;
  logic [3:0] steps_o;

  int         n_cmp = 0;
  int         n_bad = 0;

  // Responder: 0 = honest comparator, 1 = always GT, 2 = EQ and GT together.
  int         mode = 0;
  logic [7:0] target = 8'd0;

  typedef struct {
    int         mode;
    logic [7:0] target;
    int         delay;
    bit         mid_start;
    bit         exp_found;
    bit         exp_err;
    logic [7:0] exp_result;
    int         exp_steps;
    logic [71:0] exp_probes;
  } vec_t;

  vec_t vecs[6];

  cmp_search_ctrl #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .probe_o      (probe_o),
    .probe_valid_o(probe_valid_o),
    .cmp_valid_i  (cmp_valid_i),
    .eq_i         (eq_i),
    .gt_i         (gt_i),
    .lt_i         (lt_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .found_o      (found_o),
    .err_o        (err_o),
    .result_o     (result_o),
    .steps_o      (steps_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    eq_i = (target == probe_o);
    gt_i = (target > probe_o);
    lt_i = (target < probe_o);
    if (mode == 1) begin
      eq_i = 1'b0; gt_i = 1'b1; lt_i = 1'b0;
    end else if (mode == 2) begin
      eq_i = 1'b1; gt_i = 1'b1; lt_i = 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [71:0] pk(input int p0 = 0, input int p1 = 0, input int p2 = 0,
                                     input int p3 = 0, input int p4 = 0, input int p5 = 0,
                                     input int p6 = 0, input int p7 = 0, input int p8 = 0);
    return {p8[7:0], p7[7:0], p6[7:0], p5[7:0], p4[7:0], p3[7:0], p2[7:0], p1[7:0], p0[7:0]};
  endfunction

  // Starts a search and answers each probe after v.delay idle cycles; checks the probe trace.
  task automatic run_vec(input vec_t v, input string tag);
    int         idx = 0;
    int         wait_cnt = 0;
    bit         got = 0;
    logic [7:0] held = 8'd0;
    mode   = v.mode;
    target = v.target;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (done_o) begin
        got = 1;
        break;
      end
      cmp_valid_i = 1'b0;
      start_i = (v.mid_start && c == 5);
      if (probe_valid_o) begin
        if (wait_cnt > 0) chk({tag, " probe_hold"}, int'(probe_o), int'(held));
        held = probe_o;
        if (wait_cnt == v.delay) begin
          cmp_valid_i = 1'b1;
          if (idx < 9) chk({tag, $sformatf(" probe[%0d]", idx)}, int'(probe_o),
                           int'(v.exp_probes[idx*8 +: 8]));
          idx++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      @(negedge clk);
    end
    cmp_valid_i = 1'b0;
    start_i = 1'b0;
    chk({tag, " done_seen"}, int'(got), 1);
    if (got) begin
      chk({tag, " found"}, int'(found_o), int'(v.exp_found));
      chk({tag, " err"}, int'(err_o), int'(v.exp_err));
      chk({tag, " result"}, int'(result_o), int'(v.exp_result));
      chk({tag, " steps"}, int'(steps_o), v.exp_steps);
      chk({tag, " busy_in_done"}, int'(busy_o), 0);
      chk({tag, " pvalid_in_done"}, int'(probe_valid_o), 0);
      @(negedge clk);
      chk({tag, " done_one_cycle"}, int'(done_o), 0);
      chk({tag, " result_held"}, int'(result_o), int'(v.exp_result));
    end
  endtask

  initial begin
    vecs[0] = '{0, 8'd127, 0, 0, 1, 0, 8'd127, 1, pk(127)};
    vecs[1] = '{0, 8'd0,   0, 0, 1, 0, 8'd0,   8, pk(127, 63, 31, 15, 7, 3, 1, 0)};
    vecs[2] = '{0, 8'd255, 0, 0, 1, 0, 8'd255, 9,
                pk(127, 191, 223, 239, 247, 251, 253, 254, 255)};
    vecs[3] = '{1, 8'd0,   0, 0, 0, 0, 8'd255, 9,
                pk(127, 191, 223, 239, 247, 251, 253, 254, 255)};
    vecs[4] = '{2, 8'd0,   0, 0, 0, 1, 8'd127, 1, pk(127)};
    vecs[5] = '{0, 8'd200, 3, 1, 1, 0, 8'd200, 8, pk(127, 191, 223, 207, 199, 203, 201, 200)};

    // Reset state.
    #12;
    chk("rst probe", int'(probe_o), 0);
    chk("rst pvalid", int'(probe_valid_o), 0);
    chk("rst busy", int'(busy_o), 0);
    chk("rst done", int'(done_o), 0);
    chk("rst found", int'(found_o), 0);
    chk("rst err", int'(err_o), 0);
    chk("rst result", int'(result_o), 0);
    chk("rst steps", int'(steps_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-search: outputs clear asynchronously and no done pulse follows.
    mode = 0;
    target = 8'd200;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cmp_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid busy_before_reset", int'(busy_o), 1);
    chk("mid steps_before_reset", int'(steps_o), 3);
    #1 rst_n = 1'b0;
    #1;
    chk("mid rst busy", int'(busy_o), 0);
    chk("mid rst pvalid", int'(probe_valid_o), 0);
    chk("mid rst probe", int'(probe_o), 0);
    chk("mid rst steps", int'(steps_o), 0);
    chk("mid rst result", int'(result_o), 0);
    chk("mid rst found", int'(found_o), 0);
    chk("mid rst err", int'(err_o), 0);
    cmp_valid_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mid rst no_done", int'(done_o), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post rst no_done", int'(done_o), 0);
    run_vec(vecs[5], "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmp_search_ctrl.md
Name: cmp_search_ctrl

Overview:
- Sequential initiator on the far side of the relational comparator interface. It drives a probe value into an external comparator that holds a hidden target, and consumes the EQ/GT/LT flags that come back.
- Runs a binary search to find the target. Reports the found value, a found/not-found flag, an error flag and the step count.
- Sits between a control master (start/done) and any comparator instance with the EQ/GT/LT flag contract.

Parameters:
- WIDTH, 8: width of probe/result and of the comparator operands.
- STEP_W, $clog2(WIDTH+2) (localparam): width of the step counter; holds the worst case of WIDTH+1 probes.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a search; sampled in IDLE only.
- probe  output  WIDTH  value presented to the comparator as operand b; the target is operand a.
- probe_valid  output  1  probe is valid and held stable.
- cmp_valid  input  1  comparator flags valid this cycle.
- eq_in  input  1  target == probe.
- gt_in  input  1  target > probe.
- lt_in  input  1  target < probe.
- busy  output  1  search in progress.
- done  output  1  one-cycle pulse when the search ends.
- found  output  1  search ended on EQ.
- err  output  1  flags were not one-hot on a sampled response.
- result  output  WIDTH  last probe sampled; equals the target when found=1.
- steps  output  STEP_W  number of responses consumed.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - lo=0, hi=all-ones.
  - probe=0, probe_valid=0, busy=0, done=0, found=0, err=0, result=0, steps=0.
  - Asserting reset mid-search aborts it immediately. No done pulse is produced.
- States: IDLE, PROBE, DONE.
- IDLE:
  - On start=1: lo<=0, hi<=2^WIDTH-1, steps<=0, found<=0, err<=0, then go to PROBE.
  - Result outputs from the previous search are held until this start.
- PROBE:
  - busy=1, probe_valid=1.
  - probe = lo + ((hi-lo)>>1), computed at WIDTH+1 bits and truncated. No overflow is possible because lo<=hi always holds.
  - probe is stable until cmp_valid is sampled high.
  - On cmp_valid=1, steps increments and result<=probe. Then, in priority order:
    - Flags not exactly one-hot: err<=1, go to DONE.
    - eq_in: found<=1, go to DONE.
    - gt_in and probe==hi: not found, go to DONE. Otherwise lo<=probe+1 and stay in PROBE.
    - lt_in and probe==lo: not found, go to DONE. Otherwise hi<=probe-1 and stay in PROBE.
  - The next probe appears the cycle after cmp_valid. Minimum latency is 1 cycle per step, with cmp_valid tied high.
- DONE:
  - done=1 for exactly one cycle, busy=0, probe_valid=0.
  - Unconditionally returns to IDLE.
  - start seen in DONE is ignored.
- start while busy is ignored. cmp_valid outside PROBE is ignored.
- Worst case is WIDTH+1 responses (9 for WIDTH=8).
- steps saturates at its maximum; this is unreachable with a consistent comparator.
- All outputs are registered except probe, which is a combinational function of the lo/hi registers and is only meaningful while probe_valid=1.

Decomposition:
- Package cmp_search_pkg holds:
  - enum state_t {IDLE, PROBE, DONE};
  - default WIDTH constant;
  - a function computing STEP_W.
- Single module. No sub-module is warranted; the midpoint is one expression.
- The bench reuses the existing relational comparator as the responder model.

Test Plan:
- Target 127, cmp_valid tied high, start pulse → first probe 127, EQ, then done with found=1, result=127, steps=1, err=0.
- Target 0 → probes 127,63,31,15,7,3,1,0; found=1, result=0, steps=8.
- Target 255 → probes 127,191,223,239,247,251,253,254,255; found=1, result=255, steps=9. This is the worst case, with no wrap.
- Responder always returns gt_in=1 → probes climb to 255; done with found=0, result=255, steps=9.
- Flags eq_in=1 and gt_in=1 together on the first response → done with err=1, found=0, steps=1.
- cmp_valid delayed 3 cycles per step with target 200 → probe is held stable while waiting; found=1, result=200. Also:
  - start pulsed mid-search has no effect.
  - rst_n dropped mid-search clears all outputs within the same cycle and gives no done pulse.
  - A fresh start after reset completes normally.
